// File: rtl/bus_pkg.sv
// Shared definitions for the serial system-bus ports: state encoding, default width, line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The PARITY state exists only when SLAVE_OUT_PARITY_EN is defined.
package bus_pkg;

  // Frame sequencer states; PARITY is only present in parity-enabled builds.
`ifdef SLAVE_OUT_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    WAIT_MASTER,
    START,
    DATA,
    PARITY,
    DONE
  } port_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    WAIT_MASTER,
    START,
    DATA,
    DONE
  } port_state_t;
`endif

  localparam int   DEFAULT_DATA_WIDTH = 8;
  localparam logic IDLE_LINE          = 1'b1;
  localparam logic START_BIT          = 1'b0;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: loads a word, shifts right, presents bit 0 as the serial bit.
// Latency: load or shift takes effect on the next rising edge; sout follows q[0] directly.
// Backpressure: none; the controlling FSM decides when to load and shift.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  assign sout = q[0];

  // Load has priority over shift; zero is shifted into the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/slave_out_serial_port.sv
// Slave return-path transmitter: captures a word, waits for master_ready, sends start bit + LSB-first data.
// Latency: start bit one cycle after master_ready is sampled, tx_done DATA_WIDTH+2 cycles after it.
// Backpressure: slave_ready high only in IDLE; master_ready only gates the start. SLAVE_OUT_PARITY_EN adds an even-parity bit.
module slave_out_serial_port
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  master_ready,
  input  logic                  slave_valid,
  output logic                  slave_ready,
  output logic                  tx_data,
  output logic                  tx_done
);

  // Wide enough to hold DATA_WIDTH itself, so the count never wraps inside a frame.
  localparam int              CNT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

  port_state_t      state;
  logic [CNT_W-1:0] bit_cnt;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_out;
`ifdef SLAVE_OUT_PARITY_EN
  logic             par_bit;
`endif

  // Capture only from IDLE; shift every time a data bit is moved onto the registered line.
  assign sr_load  = (state == IDLE) && slave_valid;
  assign sr_shift = (state == START) || ((state == DATA) && (bit_cnt != LAST_CNT));

  piso_shift_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (sr_load),
    .shift(sr_shift),
    .din  (data_in),
    .sout (sr_out)
  );

  // Frame sequencer; every output is registered, so the line shows the value chosen on the previous edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slave_ready <= 1'b1;
      tx_data     <= IDLE_LINE;
      tx_done     <= 1'b0;
      bit_cnt     <= '0;
`ifdef SLAVE_OUT_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_data <= IDLE_LINE;
          if (slave_valid) begin
            state       <= WAIT_MASTER;
            slave_ready <= 1'b0;
            bit_cnt     <= '0;
`ifdef SLAVE_OUT_PARITY_EN
            par_bit     <= ^data_in;
`endif
          end
        end
        WAIT_MASTER: begin
          if (master_ready) begin
            state   <= START;
            tx_data <= START_BIT;
          end
        end
        START: begin
          // Bit 0 goes on the line as START ends; the counter tracks bits already sent.
          state   <= DATA;
          tx_data <= sr_out;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        DATA: begin
          if (bit_cnt == LAST_CNT) begin
`ifdef SLAVE_OUT_PARITY_EN
            state   <= PARITY;
            tx_data <= par_bit;
`else
            state   <= DONE;
            tx_data <= IDLE_LINE;
            tx_done <= 1'b1;
`endif
          end else begin
            tx_data <= sr_out;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef SLAVE_OUT_PARITY_EN
        PARITY: begin
          state   <= DONE;
          tx_data <= IDLE_LINE;
          tx_done <= 1'b1;
        end
`endif
        DONE: begin
          state       <= IDLE;
          slave_ready <= 1'b1;
          tx_data     <= IDLE_LINE;
        end
        default: begin
          state       <= IDLE;
          slave_ready <= 1'b1;
          tx_data     <= IDLE_LINE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_out_serial_port.sv
// Bench for slave_out_serial_port: table of frames plus reset/abort sequences, scoreboard of line values.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: exercises master_ready held low, high at capture, and dropped mid-frame.
module tb_slave_out_serial_port;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       master_ready;
  logic       slave_valid;
  logic       slave_ready;
  logic       tx_data;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  slave_out_serial_port #(
    .DATA_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .master_ready(master_ready),
    .slave_valid (slave_valid),
    .slave_ready (slave_ready),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame: input word, how master_ready behaves, and the hand-written line sequence.
  // exp_seq lists transmitted data bits in order, first bit at the MSB.
  typedef struct {
    logic [7:0] data;
    bit         mr_early;
    int         wait_n;
    bit         disturb;
    logic [7:0] exp_seq;
    logic       exp_par;
  } vec_t;

  typedef struct {
    logic tx;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    int   idx;
    chk("idle_ready", 32'(slave_ready), 32'd1);
    data_in      = v.data;
    slave_valid  = 1'b1;
    master_ready = v.mr_early;
    // Scoreboard: whole expected line sequence for this frame.
    e.tx = 1'b0; e.done = 1'b0; exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.tx = v.exp_seq[7-i]; e.done = 1'b0; exp_q.push_back(e);
    end
`ifdef SLAVE_OUT_PARITY_EN
    e.tx = v.exp_par; e.done = 1'b0; exp_q.push_back(e);
`endif
    e.tx = 1'b1; e.done = 1'b1; exp_q.push_back(e);
    step();  // capture edge
    chk("wait_ready", 32'(slave_ready), 32'd0);
    chk("wait_tx", 32'(tx_data), 32'd1);
    chk("wait_done", 32'(tx_done), 32'd0);
    if (!v.mr_early) begin
      for (int k = 0; k < v.wait_n; k++) begin
        step();
        chk("hold_ready", 32'(slave_ready), 32'd0);
        chk("hold_tx", 32'(tx_data), 32'd1);
        chk("hold_done", 32'(tx_done), 32'd0);
      end
    end
    slave_valid  = 1'b0;
    master_ready = 1'b1;
    idx = 0;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      chk("line_tx", 32'(tx_data), 32'(e.tx));
      chk("line_done", 32'(tx_done), 32'(e.done));
      chk("line_ready", 32'(slave_ready), 32'd0);
      if (v.disturb && idx == 3) begin
        master_ready = 1'b0;
        data_in      = 8'hFF;
        slave_valid  = 1'b1;
      end
      if (v.disturb && idx == 6) slave_valid = 1'b0;
      idx++;
    end
    step();
    chk("post_ready", 32'(slave_ready), 32'd1);
    chk("post_done", 32'(tx_done), 32'd0);
    chk("post_tx", 32'(tx_data), 32'd1);
  endtask

  initial begin
    vecs[0] = '{data: 8'hAA, mr_early: 1'b0, wait_n: 5, disturb: 1'b0, exp_seq: 8'b01010101, exp_par: 1'b0};
    vecs[1] = '{data: 8'h3C, mr_early: 1'b1, wait_n: 0, disturb: 1'b0, exp_seq: 8'b00111100, exp_par: 1'b0};
    vecs[2] = '{data: 8'h81, mr_early: 1'b1, wait_n: 0, disturb: 1'b1, exp_seq: 8'b10000001, exp_par: 1'b0};
    vecs[3] = '{data: 8'h07, mr_early: 1'b0, wait_n: 2, disturb: 1'b0, exp_seq: 8'b11100000, exp_par: 1'b1};
    vecs[4] = '{data: 8'h00, mr_early: 1'b1, wait_n: 0, disturb: 1'b0, exp_seq: 8'b00000000, exp_par: 1'b0};

    reset        = 1'b1;
    data_in      = 8'h00;
    master_ready = 1'b0;
    slave_valid  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_ready", 32'(slave_ready), 32'd1);
      chk("rst_tx", 32'(tx_data), 32'd1);
      chk("rst_done", 32'(tx_done), 32'd0);
    end
    reset = 1'b0;
    step();
    chk("after_rst_ready", 32'(slave_ready), 32'd1);
    chk("after_rst_tx", 32'(tx_data), 32'd1);

    // Frames run back to back: each capture happens on the first IDLE edge after DONE.
    for (int n = 0; n < 5; n++) run_frame(vecs[n]);

    // Abort: reset while data bit 4 of 0x5A is on the line.
    data_in      = 8'h5A;
    slave_valid  = 1'b1;
    master_ready = 1'b1;
    step();  // capture
    slave_valid = 1'b0;
    step();  // start bit
    chk("abort_start", 32'(tx_data), 32'd0);
    repeat (5) step();
    chk("abort_bit4", 32'(tx_data), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_tx", 32'(tx_data), 32'd1);
    chk("abort_ready", 32'(slave_ready), 32'd1);
    chk("abort_done", 32'(tx_done), 32'd0);
    reset        = 1'b0;
    master_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("abort_quiet_done", 32'(tx_done), 32'd0);
      chk("abort_quiet_tx", 32'(tx_data), 32'd1);
    end

    run_frame(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
